// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage. Owns the fetch PC, issues in-order
// requests to instruction memory, buffers returned words with their PCs in a
// DEPTH-entry FIFO and presents the head to decode. A redirect from decode
// flushes the FIFO and discards every response still in flight.
//
// Optional build macro FETCH_BYPASS_EN: a response that arrives while the FIFO
// is empty, nothing is pending discard and decode is ready is handed to decode
// in the same cycle instead of being written to the FIFO.
`timescale 1ns/1ps

module fetch_queue #(
    parameter int                          ADDRESS_BITS = 16,
    parameter int                          DEPTH        = 4,
    parameter logic [ADDRESS_BITS-1:0]     RESET_PC     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    imem_req_valid,
    output logic [ADDRESS_BITS-1:0] imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_rsp_valid,
    input  logic [31:0]             imem_rsp_data,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [ADDRESS_BITS-1:0] PC,
    output logic [31:0]             instruction,
    input  logic                    next_PC_select,
    input  logic [ADDRESS_BITS-1:0] target_PC
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [ADDRESS_BITS-1:0] PC_STEP = ADDRESS_BITS'(4);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_BITS-1:0] rsp_pc_q, rsp_pc_d;      // PC of the next response that will be kept
    logic [CNT_W-1:0]        outstanding_q, outstanding_d;
    logic [CNT_W-1:0]        drop_q, drop_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;

    logic [ADDRESS_BITS-1:0] pc_mem_q   [DEPTH];
    logic [31:0]             word_mem_q [DEPTH];

    logic                    fifo_empty;
    logic                    rsp_take;
    logic                    rsp_keep;
    logic                    bypass;
    logic                    pop_fire;
    logic                    fifo_pop;
    logic                    redirect;
    logic                    push;
    logic                    req_fire;
    logic [CNT_W:0]          credits_used;
    logic [ADDRESS_BITS-1:0] target_aligned;
    logic                    unused_target_bits;

    assign unused_target_bits = ^target_PC[1:0];
    assign target_aligned     = {target_PC[ADDRESS_BITS-1:2], 2'b00};

    assign fifo_empty = (count_q == '0);
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_take   = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_keep   = rsp_take && (drop_q == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_keep && fifo_empty && inst_ready;
`else
    assign bypass = 1'b0;
`endif

    assign inst_valid  = !fifo_empty || bypass;
    assign PC          = !fifo_empty ? pc_mem_q[rd_ptr_q]
                       : bypass      ? rsp_pc_q
                       :               '0;
    assign instruction = !fifo_empty ? word_mem_q[rd_ptr_q]
                       : bypass      ? imem_rsp_data
                       :               NOP;

    assign pop_fire = inst_valid && inst_ready;
    assign fifo_pop = pop_fire && !fifo_empty;
    assign redirect = pop_fire && next_PC_select;
    // Words arriving in a redirect cycle belong to the abandoned stream.
    assign push     = rsp_keep && !bypass && !redirect;

    // Every accepted request reserves a FIFO slot until its word is consumed.
    assign credits_used   = (CNT_W + 1)'(outstanding_q) + (CNT_W + 1)'(count_q);
    assign imem_req_valid = (state_q == ST_RUN) && (credits_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Next-state logic for sequencing, fetch PC, credit counters and FIFO pointers.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (rsp_take) begin
            outstanding_d = outstanding_d - CNT_W'(1);
        end
        if (req_fire) begin
            outstanding_d = outstanding_d + CNT_W'(1);
            fetch_pc_d    = fetch_pc_q + PC_STEP;
        end

        if (rsp_take && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
        end
        if (rsp_keep) begin
            rsp_pc_d = rsp_pc_q + PC_STEP;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(fifo_pop);

        // Everything still in flight, including a request accepted right now,
        // belongs to the old stream and is discarded when it returns.
        if (redirect) begin
            fetch_pc_d = target_aligned;
            rsp_pc_d   = target_aligned;
            drop_d     = outstanding_d;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end

        if ((state_q == ST_IDLE) && start) begin
            state_d    = ST_RUN;
            fetch_pc_d = RESET_PC;
            rsp_pc_d   = RESET_PC;
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // FIFO storage; contents are only observed through count_q, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
            word_mem_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized bench for fetch_queue with an in-bench memory and
// a transaction-level reference model (queues of in-flight requests, each
// tagged with its address and whether a redirect has abandoned it).
`timescale 1ns/1ps

module tb_fetch_queue;

    localparam int          AW    = 16;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RPC   = 16'h0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          start;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          inst_valid;
    logic          inst_ready;
    logic [AW-1:0] PC;
    logic [31:0]   instruction;
    logic          next_PC_select;
    logic [AW-1:0] target_PC;

    fetch_queue #(.ADDRESS_BITS(AW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clock          (clock),
        .reset          (rst_n),
        .start          (start),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .PC             (PC),
        .instruction    (instruction),
        .next_PC_select (next_PC_select),
        .target_PC      (target_PC)
    );

    always #5 clock = ~clock;

    typedef struct { logic [15:0] addr; int due; bit doomed; } req_t;
    typedef struct { logic [15:0] pc; logic [31:0] word; } ent_t;

    req_t        pend[$];     // accepted requests awaiting their response
    ent_t        fifo_m[$];   // words waiting for decode
    logic [15:0] log_pc[$];   // PCs consumed by decode
    int          log_cyc[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat, p_mrdy, p_drdy, p_rsp, p_sel;
    int          sel_on_pc = -1;
    logic [15:0] sel_tgt;
    bit          start_req = 0;
    bit          running = 0;
    logic [15:0] fpc = RPC;
    int          req_count = 0;
    int          c0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [15:0] a);
        return {a ^ 16'hC35A, a};
    endfunction

    function automatic bit pct(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    function automatic logic [31:0] log_at(input int k);
        if (k < log_pc.size()) return {16'h0, log_pc[k]};
        return 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: drive inputs at the falling edge, compare, advance model at the rising edge.
    task automatic step();
        bit          rsp_now, byp, ev, erv, pop, redir;
        logic [15:0] epc;
        logic [31:0] ein;
        req_t        e;
        rsp_now = (pend.size() > 0) && (pend[0].due <= cyc) && pct(p_rsp);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? word_of(pend[0].addr) : $urandom;
        imem_req_ready = pct(p_mrdy);
        inst_ready     = pct(p_drdy);
        start          = start_req;
        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = rsp_now && !pend[0].doomed && (fifo_m.size() == 0) && inst_ready;
`endif
        ev  = (fifo_m.size() > 0) || byp;
        epc = (fifo_m.size() > 0) ? fifo_m[0].pc : (byp ? pend[0].addr : 16'h0);
        ein = (fifo_m.size() > 0) ? fifo_m[0].word : (byp ? word_of(pend[0].addr) : NOP);
        erv = running && ((pend.size() + fifo_m.size()) < DEPTH);
        next_PC_select = 1'b0;
        target_PC      = 16'($urandom);
        if (sel_on_pc >= 0 && ev && inst_ready && epc == 16'(sel_on_pc)) begin
            next_PC_select = 1'b1;
            target_PC      = sel_tgt;
            sel_on_pc      = -1;
        end else if (pct(p_sel)) begin
            next_PC_select = 1'b1;
            if (pct(25)) target_PC = 16'hFFF0 | 16'($urandom_range(15, 0));
        end
        #1;
        check_val("inst_valid", {31'h0, inst_valid}, {31'h0, ev});
        if (ev) check_val("PC", {16'h0, PC}, {16'h0, epc});
        check_val("instruction", instruction, ein);
        check_val("req_valid", {31'h0, imem_req_valid}, {31'h0, erv});
        check_val("req_addr", {16'h0, imem_req_addr}, {16'h0, fpc});
        @(posedge clock);
        pop   = ev && inst_ready;
        redir = pop && next_PC_select;
        if (pop) begin
            log_pc.push_back(epc);
            log_cyc.push_back(cyc);
        end
        if (pop && !byp) void'(fifo_m.pop_front());
        if (rsp_now) begin
            e = pend.pop_front();
            if (!byp && !e.doomed && !redir) fifo_m.push_back('{pc: e.addr, word: word_of(e.addr)});
        end
        if (redir) begin
            fifo_m.delete();
            foreach (pend[i]) pend[i].doomed = 1'b1;
        end
        if (erv && imem_req_ready) begin
            pend.push_back('{addr: fpc, due: cyc + lat, doomed: redir});
            fpc += 16'd4;
            req_count++;
        end
        if (redir) fpc = target_PC & 16'hFFFC;
        if (start && !running) begin
            running = 1'b1;
            fpc     = RPC;
        end
        cyc++;
        @(negedge clock);
    endtask

    // Assert reset between edges, check the outputs react at once, then release.
    task automatic reset_dut();
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        check_val("rst_instruction", instruction, NOP);
        check_val("rst_PC", {16'h0, PC}, 32'h0);
        check_val("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check_val("rst_req_addr", {16'h0, imem_req_addr}, {16'h0, RPC});
        start = 1'b0; imem_rsp_valid = 1'b0; next_PC_select = 1'b0; inst_ready = 1'b0;
        pend.delete(); fifo_m.delete(); log_pc.delete(); log_cyc.delete();
        running = 1'b0; fpc = RPC; req_count = 0; sel_on_pc = -1;
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic set_knobs(input int l, input int mr, input int dr, input int rs, input int sl);
        lat = l; p_mrdy = mr; p_drdy = dr; p_rsp = rs; p_sel = sl;
    endtask

    task automatic do_start();
        start_req = 1'b1;
        c0 = cyc;
        step();
        start_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0; inst_ready = 1'b0; next_PC_select = 1'b0; target_PC = 16'h0;
        set_knobs(1, 100, 100, 100, 0);
        @(negedge clock);
        reset_dut();

        // Latency 1, everything ready: one instruction per cycle.
        set_knobs(1, 100, 100, 100, 0);
        do_start();
        repeat (10) step();
`ifdef FETCH_BYPASS_EN
        check_val("first_valid_cycle", 32'(log_cyc.size() > 0 ? log_cyc[0] - c0 : -1), 32'd2);
`else
        check_val("first_valid_cycle", 32'(log_cyc.size() > 0 ? log_cyc[0] - c0 : -1), 32'd3);
`endif
        for (int k = 0; k < 6; k++) begin
            check_val("stream_pc", log_at(k), 32'(4 * k));
            check_val("stream_gap", 32'(k < log_cyc.size() ? log_cyc[k] - log_cyc[0] : -1), 32'(k));
        end

        // Mid-stream reset, then decode stalled: exactly DEPTH requests.
        reset_dut();
        set_knobs(1, 100, 0, 100, 0);
        do_start();
        repeat (10) step();
        check_val("stall_req_count", 32'(req_count), 32'(DEPTH));
        check_val("stall_req_valid", {31'h0, imem_req_valid}, 32'h0);
        set_knobs(1, 100, 100, 100, 0);
        repeat (8) step();
        for (int k = 0; k < 4; k++) check_val("stall_drain_pc", log_at(k), 32'(4 * k));

        // Latency 3, redirect on PC 0x0004 to 0x0129.
        reset_dut();
        set_knobs(3, 100, 100, 100, 0);
        sel_on_pc = 4; sel_tgt = 16'h0129;
        do_start();
        repeat (20) step();
        check_val("redir_fired", 32'(sel_on_pc), 32'hFFFF_FFFF);
        check_val("redir_pc0", log_at(0), 32'h0000);
        check_val("redir_pc1", log_at(1), 32'h0004);
        check_val("redir_pc2", log_at(2), 32'h0128);
        check_val("redir_pc3", log_at(3), 32'h012C);

        // Select while decode is not ready is ignored.
        reset_dut();
        set_knobs(1, 100, 0, 100, 100);
        do_start();
        repeat (8) step();
        set_knobs(1, 100, 100, 100, 0);
        repeat (6) step();
        for (int k = 0; k < 4; k++) check_val("ignored_sel_pc", log_at(k), 32'(4 * k));

        // Fetch PC wraps past 0xFFFC.
        reset_dut();
        set_knobs(1, 100, 100, 100, 0);
        sel_on_pc = 0; sel_tgt = 16'hFFFA;
        do_start();
        repeat (12) step();
        check_val("wrap_pc1", log_at(1), 32'hFFF8);
        check_val("wrap_pc2", log_at(2), 32'hFFFC);
        check_val("wrap_pc3", log_at(3), 32'h0000);
        check_val("wrap_pc4", log_at(4), 32'h0004);

        // Randomized segments.
        for (int s = 0; s < 6; s++) begin
            reset_dut();
            set_knobs(int'($urandom_range(4, 1)), int'($urandom_range(100, 40)),
                      int'($urandom_range(100, 30)), int'($urandom_range(100, 50)),
                      int'($urandom_range(15, 0)));
            do_start();
            repeat (250) step();
            check_val("rand_progress", {31'h0, log_pc.size() > 0}, 32'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
